// File: rtl/crossy_pkg.sv
// Shared state encodings, default timing constants and saturating counter
// helpers for the crossyroad game sequencing logic.
package crossy_pkg;

    localparam int SCORE_W          = 7;
    localparam int DEF_DEB_FRAMES   = 2;
    localparam int DEF_DEAD_FRAMES  = 90;
    localparam int DEF_FLASH_FRAMES = 8;
    localparam int CNT_W            = 8;

    typedef enum logic [1:0] {
        GS_RESTART = 2'd0,
        GS_IDLE    = 2'd1,
        GS_PLAY    = 2'd2,
        GS_DEAD    = 2'd3
    } game_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == 8'd0) ? v : v - 8'd1;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle between the game sequencer and its environment: frame/button/collision
// inputs and the scroll/score control outputs.
interface game_ctrl_if #(
    parameter int SCORE_W = crossy_pkg::SCORE_W
);
    logic               i_frame_tick;
    logic               i_move_btn;
    logic               i_collision;
    logic [SCORE_W-1:0] i_score;
    logic               o_world_rst;
    logic               o_run;
    logic               o_move;
    logic               o_flash;
    logic [1:0]         o_state;
    logic [SCORE_W-1:0] o_high_score;

    modport master (
        output i_frame_tick, i_move_btn, i_collision, i_score,
        input  o_world_rst, o_run, o_move, o_flash, o_state, o_high_score
    );

    modport slave (
        input  i_frame_tick, i_move_btn, i_collision, i_score,
        output o_world_rst, o_run, o_move, o_flash, o_state, o_high_score
    );
endinterface

// File: rtl/btn_debounce.sv
// Move-button conditioning: 2-flop synchroniser, frame-tick stability counter
// and press-edge detector that only fires once the button was seen released.
module btn_debounce #(
    parameter int DEB_FRAMES = crossy_pkg::DEF_DEB_FRAMES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);
    import crossy_pkg::*;

    logic             sync1_r, sync2_r;
    logic             level_r, press_r, armed_r;
    logic [CNT_W-1:0] stab_cnt_r;
    logic             differs_s, settle_s;

    // Decide whether this tick's sample completes a stable run
    always_comb begin
        differs_s = (sync2_r != level_r);
        settle_s  = i_tick && differs_s && (stab_cnt_r >= CNT_W'(DEB_FRAMES - 1));
    end

    // A confirmed low sample arms edge detection, so a button held from reset never counts
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            level_r    <= 1'b0;
            press_r    <= 1'b0;
            armed_r    <= 1'b0;
            stab_cnt_r <= 8'd0;
        end else begin
            sync1_r <= i_btn;
            sync2_r <= sync1_r;
            if (!i_tick) begin
                press_r <= 1'b0;
            end else if (!differs_s) begin
                press_r    <= 1'b0;
                stab_cnt_r <= 8'd0;
                armed_r    <= armed_r | ~level_r;
            end else if (settle_s) begin
                level_r    <= sync2_r;
                press_r    <= sync2_r & armed_r;
                stab_cnt_r <= 8'd0;
            end else begin
                press_r    <= 1'b0;
                stab_cnt_r <= sat_inc(stab_cnt_r);
            end
        end
    end

    assign o_level = level_r;
    assign o_press = press_r;

endmodule

// File: rtl/game_ctrl.sv
// Frame-synchronous game sequencer (restart / attract / play / death flash)
// with debounced move pulses and a power-on session high score.
module game_ctrl #(
    parameter int DEB_FRAMES   = crossy_pkg::DEF_DEB_FRAMES,
    parameter int DEAD_FRAMES  = crossy_pkg::DEF_DEAD_FRAMES,
    parameter int FLASH_FRAMES = crossy_pkg::DEF_FLASH_FRAMES,
    parameter int SCORE_W      = crossy_pkg::SCORE_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    game_ctrl_if.slave bus
);
    import crossy_pkg::*;

    game_state_e        state_r, state_nxt_s;
    logic               boot_r;
    logic               level_unused_s, press_s;
    logic               hit_r, dead_go_s, death_done_s, flash_wrap_s;
    logic [CNT_W-1:0]   death_cnt_r, flash_cnt_r;
    logic               flash_r, world_rst_r, run_r, move_r;
    logic               world_rst_nxt_s, run_nxt_s, move_nxt_s;
    logic [SCORE_W-1:0] high_score_r;

    btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tick  (bus.i_frame_tick),
        .i_btn   (bus.i_move_btn),
        .o_level (level_unused_s),
        .o_press (press_s)
    );

    // State register; boot_r holds RESTART one extra cycle after reset release
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= GS_RESTART;
            boot_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            boot_r  <= 1'b0;
        end
    end

    // Frame-tick event decodes shared by the FSM and the counters
    always_comb begin
        dead_go_s    = bus.i_frame_tick && (hit_r || bus.i_collision);
        death_done_s = bus.i_frame_tick && (death_cnt_r <= 8'd1);
        flash_wrap_s = bus.i_frame_tick && (flash_cnt_r <= 8'd1);
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            GS_RESTART: state_nxt_s = boot_r ? GS_RESTART : GS_IDLE;
            GS_IDLE:    state_nxt_s = press_s ? GS_PLAY : GS_IDLE;
            GS_PLAY:    state_nxt_s = dead_go_s ? GS_DEAD : GS_PLAY;
            GS_DEAD:    state_nxt_s = death_done_s ? GS_RESTART : GS_DEAD;
            default:    state_nxt_s = GS_RESTART;
        endcase
    end

    // Output decode; a press edge landing with the death tick finds PLAY already left
    always_comb begin
        world_rst_nxt_s = (state_nxt_s == GS_RESTART);
        run_nxt_s       = (state_nxt_s == GS_PLAY);
        move_nxt_s      = (state_r == GS_PLAY) && press_s && !dead_go_s;
    end

    // Output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            world_rst_r <= 1'b1;
            run_r       <= 1'b0;
            move_r      <= 1'b0;
        end else begin
            world_rst_r <= world_rst_nxt_s;
            run_r       <= run_nxt_s;
            move_r      <= move_nxt_s;
        end
    end

    // Sticky hit flag, death countdown and flash half-period timer
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hit_r       <= 1'b0;
            flash_r     <= 1'b0;
            death_cnt_r <= 8'd0;
            flash_cnt_r <= 8'd0;
        end else if (state_r == GS_PLAY) begin
            hit_r       <= dead_go_s ? 1'b0 : (hit_r | bus.i_collision);
            flash_r     <= dead_go_s;
            death_cnt_r <= CNT_W'(DEAD_FRAMES);
            flash_cnt_r <= CNT_W'(FLASH_FRAMES);
        end else if (state_r == GS_DEAD) begin
            hit_r <= 1'b0;
            if (bus.i_frame_tick) begin
                death_cnt_r <= sat_dec(death_cnt_r);
                flash_cnt_r <= flash_wrap_s ? CNT_W'(FLASH_FRAMES) : sat_dec(flash_cnt_r);
                flash_r     <= death_done_s ? 1'b0 : (flash_r ^ flash_wrap_s);
            end
        end else begin
            hit_r   <= 1'b0;
            flash_r <= 1'b0;
        end
    end

    // Session best, captured on entry to DEAD and cleared only by power-on reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            high_score_r <= {SCORE_W{1'b0}};
        end else if ((state_r == GS_PLAY) && dead_go_s && (bus.i_score > high_score_r)) begin
            high_score_r <= bus.i_score;
        end
    end

    assign bus.o_world_rst  = world_rst_r;
    assign bus.o_run        = run_r;
    assign bus.o_move       = move_r;
    assign bus.o_flash      = flash_r;
    assign bus.o_state      = state_r;
    assign bus.o_high_score = high_score_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: frame-level stimulus (directed then
// random) compared against a per-frame behavioural model of the game rules.
module tb_game_ctrl;
    import crossy_pkg::*;

    localparam int FC     = 12;
    localparam int DEB    = 2;
    localparam int DEADF  = 90;
    localparam int FLASHF = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // model state, using the documented o_state encoding
    int   m_state, m_hs, m_dead_ticks, m_exp_moves, m_exp_rst;
    logic m_lvl;
    bit   m_armed;
    logic smp_q[$];

    game_ctrl_if bus ();

    game_ctrl #(
        .DEB_FRAMES   (DEB),
        .DEAD_FRAMES  (DEADF),
        .FLASH_FRAMES (FLASHF),
        .SCORE_W      (SCORE_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic flash_exp();
        return (m_state == 3) && (((m_dead_ticks / FLASHF) % 2) == 0);
    endfunction

    // debounced level changes once the last DEB tick samples all disagree with it
    task automatic model_debounce(input logic b, output bit press);
        bit all_diff;
        press = 1'b0;
        if (b == 1'b0 && m_lvl == 1'b0) m_armed = 1'b1;
        smp_q.push_back(b);
        all_diff = (smp_q.size() >= DEB);
        foreach (smp_q[i]) begin
            if (i >= smp_q.size() - DEB && smp_q[i] == m_lvl) all_diff = 1'b0;
        end
        if (all_diff) begin
            press = b & m_armed;
            m_lvl = b;
            smp_q.delete();
        end
    endtask

    task automatic model_tick(input logic b, input bit coll, input int score);
        bit press;
        model_debounce(b, press);
        m_exp_moves = 0;
        m_exp_rst   = 0;
        case (m_state)
            1: if (press) m_state = 2;
            2: begin
                if (coll) begin
                    m_state      = 3;
                    m_dead_ticks = 0;
                    if (score > m_hs) m_hs = score;
                end else if (press) begin
                    m_exp_moves = 1;
                end
            end
            3: begin
                m_dead_ticks++;
                if (m_dead_ticks == DEADF) begin
                    m_state   = 1;
                    m_exp_rst = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_state      = 1;
        m_hs         = 0;
        m_dead_ticks = 0;
        m_exp_moves  = 0;
        m_exp_rst    = 0;
        m_lvl        = 1'b0;
        m_armed      = 1'b0;
        smp_q.delete();
    endtask

    // one frame: observe effects of the previous tick, maybe collide mid-frame, then tick
    task automatic frame(input logic b, input bit coll, input int score);
        int moves = 0;
        int rsts  = 0;
        int rsts_st = 0;
        int cpos;
        cpos = $urandom_range(4, FC - 3);
        bus.i_move_btn = b;
        bus.i_score    = SCORE_W'(score);
        for (int c = 0; c < FC; c++) begin
            if (bus.o_move === 1'b1) moves++;
            if (bus.o_world_rst === 1'b1) rsts++;
            if (bus.o_state === 2'd0) rsts_st++;
            bus.i_collision = coll && (c == cpos);
            @(negedge clk);
        end
        bus.i_collision = 1'b0;
        check("move_pulses", moves, m_exp_moves);
        check("world_rst_cycles", rsts, m_exp_rst);
        check("restart_cycles", rsts_st, m_exp_rst);
        check("state", bus.o_state, m_state);
        check("run", bus.o_run, m_state == 2);
        check("flash", bus.o_flash, flash_exp());
        check("high_score", bus.o_high_score, m_hs);
        bus.i_frame_tick = 1'b1;
        @(negedge clk);
        bus.i_frame_tick = 1'b0;
        model_tick(b, coll, score);
    endtask

    task automatic do_reset(input logic b);
        bus.i_move_btn = b;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_state", bus.o_state, 0);
        check("rst_world_rst", bus.o_world_rst, 1);
        check("rst_run", bus.o_run, 0);
        check("rst_move", bus.o_move, 0);
        check("rst_flash", bus.o_flash, 0);
        check("rst_high_score", bus.o_high_score, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_state", bus.o_state, 0);
        check("rel_world_rst", bus.o_world_rst, 1);
        @(negedge clk);
        check("post_state", bus.o_state, 1);
        check("post_world_rst", bus.o_world_rst, 0);
        check("post_run", bus.o_run, 0);
        check("post_high_score", bus.o_high_score, 0);
        model_reset();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        bus.i_frame_tick = 1'b0;
        bus.i_move_btn   = 1'b0;
        bus.i_collision  = 1'b0;
        bus.i_score      = '0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);

        repeat (2) frame(1'b0, 1'b0, 0);
        repeat (3) frame(1'b1, 1'b0, 0);        // start press: PLAY, no move
        repeat (3) frame(1'b0, 1'b0, 0);
        repeat (3) frame(1'b1, 1'b0, 0);        // in-game press: one move
        repeat (3) frame(1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) frame(1'(i % 2 == 0), 1'b0, 0);   // bounce
        frame(1'b0, 1'b0, 12);
        frame(1'b0, 1'b1, 12);                  // death with score 12
        for (int i = 0; i < DEADF + 3; i++)
            frame((i < DEADF - 4) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 12);

        repeat (3) frame(1'b1, 1'b0, 5);        // game 2
        repeat (3) frame(1'b0, 1'b0, 5);
        frame(1'b1, 1'b0, 5);
        frame(1'b1, 1'b1, 5);                   // press edge and collision on one tick
        repeat (2) frame(1'b1, 1'b0, 5);
        repeat (18) frame(1'b0, 1'b0, 5);
        do_reset(1'b1);                         // mid-DEAD reset, button held through it
        repeat (4) frame(1'b1, 1'b0, 0);
        repeat (3) frame(1'b0, 1'b0, 0);
        repeat (3) frame(1'b1, 1'b0, 0);

        b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) b = ~b;
            frame(b, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 127)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
